mips_dcache: RTL and testbench
==============================

Name: mips_dcache

Overview:
- Direct-mapped, write-through, write-allocate data cache between the MEM stage and the word-wide main data memory.
- Serves load/store requests from the MEM stage.
- Returns a one-cycle `hit` strobe that the pipeline uses as its "access complete" signal.
- Hides a fixed multi-cycle memory latency with a small wait-counter FSM, and performs byte-store read-modify-write.

Parameters:
- INDEX_BITS, 11, line index width; NUM_LINES = 2**INDEX_BITS one-word (4-byte) lines.
- MEM_LATENCY, 4, cycles main memory needs per read or write (must be >= 1).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_b  input  1  synchronous reset, active-high (1 = reset).
- cache_en  input  1  request valid from MEM stage.
- mem_write  input  1  1 = store, 0 = load.
- is_LB_SB  input  1  1 = byte access, 0 = word access.
- alu_result  input  32  byte address.
- rt_data  input  32  store data; byte stores use rt_data[7:0].
- hit  output  1  access complete this cycle.
- cache_data_out  output  8x[0:3]  line bytes, [0] = lowest address.
- mem_block  output  2  alu_result[1:0], for WB byte select.
- mem_addr  output  32  {alu_result[31:2],2'b00}.
- mem_data_in  output  8x[0:3]  word to memory.
- mem_write_en  output  1  memory write strobe.
- mem_data_out  input  8x[0:3]  word from memory, valid MEM_LATENCY cycles after address is held.

Behaviour:
- Address split: index = alu_result[INDEX_BITS+1:2]; tag = alu_result[31:INDEX_BITS+2]. Lookup match = valid[index] && tag_ram[index]==tag.
- Storage: per line valid bit, tag, 4 data bytes. The data array may be reg-based and is not reset. Only valid bits are reset.
- Reset (rst_b=1 at an edge): all valid bits cleared, state=IDLE, counter=0. After reset: hit=0, mem_write_en=0, cache_data_out=0.
- States: IDLE, RD_WAIT, WR_WAIT. Counter width is clog2(MEM_LATENCY)+1.
- IDLE transitions:
  - cache_en=0: stay; hit=0.
  - Load, match: hit=1 combinationally; cache_data_out = line; stay (zero-wait).
  - Load, no match: go RD_WAIT, counter=1.
  - Store, match, or word store (is_LB_SB=0) regardless of match: go WR_WAIT, counter=1.
  - Byte store, no match: go RD_WAIT (allocate first).
- RD_WAIT:
  - mem_write_en=0; mem_addr held.
  - While counter==MEM_LATENCY: write mem_data_out into the line, set valid and tag, return to IDLE. Otherwise counter++.
  - hit stays 0 in RD_WAIT. Completion occurs via the IDLE lookup on the next cycle.
  - Byte-store miss then re-enters via IDLE to WR_WAIT.
- WR_WAIT:
  - mem_write_en=1 in every WR_WAIT cycle.
  - mem_data_in = word store: rt_data. Byte store: current line bytes with byte [alu_result[1:0]] replaced by rt_data[7:0].
  - While counter==MEM_LATENCY: hit=1, write the same merged word into the line, set valid/tag, return to IDLE. Otherwise counter++.
- Outside WR_WAIT: mem_write_en=0; mem_data_in is don't-care but drives the merged value.
- cache_data_out = line bytes when hit=1 for a load, else 0.
- Latency, counted from the request-present cycle 0:
  - Load hit: hit in cycle 0.
  - Load miss: hit in cycle MEM_LATENCY+1.
  - Word store: hit in cycle MEM_LATENCY.
  - Byte-store miss: hit in cycle 2*MEM_LATENCY+1.
- The requester holds all request inputs stable until hit. If cache_en drops during RD_WAIT or WR_WAIT, the operation still completes (fill or write), but hit is suppressed.
- Back-to-back: the cycle after hit, IDLE accepts a new request. A load to a just-filled or just-written line hits with zero wait.
- Index aliasing: a fill or write to an index with a different valid tag overwrites that line. No writeback is needed (write-through).
- Reset mid-operation: FSM aborts immediately at the reset edge; mem_write_en=0 next cycle. The partially written memory word is undefined. The line is not updated.

Test Plan:
- Reset, then load 0x100: RD_WAIT for 4 cycles, hit=1 at cycle 5 with memory word 0xDEADBEEF; a repeat load of 0x100 hits at cycle 0.
- Word store 0x11223344 to 0x100 after fill: mem_write_en high cycles 1-4, hit at cycle 4; next load 0x100 returns 0x11223344 with zero wait.
- Byte store 0xAA to 0x203, cold: fill (cycles 1-4), WR_WAIT; mem_data_in byte[3]=0xAA with other bytes from memory; hit at cycle 9.
- Alias with INDEX_BITS=11: load 0x0000, then load 0x2000 (same index, new tag) misses; reload 0x0000 misses again.
- Reset asserted in WR_WAIT cycle 2: mem_write_en=0 next cycle, state IDLE, and a following load to the same address misses.
- cache_en dropped during RD_WAIT: no hit pulse, the line still fills, and a later load to that address hits immediately.

Source files
------------

// File: rtl/mips_dcache.sv
// Direct-mapped, write-through, write-allocate data cache with one-word lines.
// A wait-counter FSM hides the fixed main-memory latency and performs byte-store read-modify-write.
//
// state   | meaning
// IDLE    | lookup; a load that matches completes here with zero wait
// RD_WAIT | line fill from memory (loads and byte-store misses)
// WR_WAIT | memory write of the word or merged byte; line updated on the last cycle

module mips_dcache #(
    parameter int INDEX_BITS  = 11,
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        cache_en,
    input  logic        mem_write,
    input  logic        is_LB_SB,
    input  logic [31:0] alu_result,
    input  logic [31:0] rt_data,
    output logic        hit,
    output logic [7:0]  cache_data_out [0:3],
    output logic [1:0]  mem_block,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_data_in [0:3],
    output logic        mem_write_en,
    input  logic [7:0]  mem_data_out [0:3]
);

    localparam int NUM_LINES = 2 ** INDEX_BITS;
    localparam int TAG_BITS  = 30 - INDEX_BITS;
    localparam int CNT_BITS  = $clog2(MEM_LATENCY) + 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(MEM_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT
    } state_t;

    state_t                state;
    logic [CNT_BITS-1:0]   count;
    logic [NUM_LINES-1:0]  valid_bits;
    logic [TAG_BITS-1:0]   tag_ram  [NUM_LINES];
    logic [31:0]           data_ram [NUM_LINES];

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [31:0]           line_word;
    logic [31:0]           merged_word;
    logic [31:0]           fill_word;
    logic [31:0]           line_wr_word;
    logic                  match;
    logic                  last;
    logic                  load_hit;
    logic                  line_wr;

    assign index     = alu_result[INDEX_BITS+1:2];
    assign tag       = alu_result[31:INDEX_BITS+2];
    assign line_word = data_ram[index];
    assign match     = valid_bits[index] && (tag_ram[index] == tag);
    assign last      = (count == CNT_LAST);

    assign load_hit     = (state == IDLE) && cache_en && !mem_write && match;
    assign hit          = load_hit || ((state == WR_WAIT) && last && cache_en);
    assign mem_write_en = (state == WR_WAIT);
    assign mem_block    = alu_result[1:0];
    assign mem_addr     = {alu_result[31:2], 2'b00};

    // Lines are stored big-endian: byte 0 (lowest address) sits in bits [31:24].
    assign fill_word    = {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
    assign line_wr      = (state != IDLE) && last;
    assign line_wr_word = (state == RD_WAIT) ? fill_word : merged_word;

    always_comb begin
        merged_word = rt_data;
        if (is_LB_SB) begin
            merged_word = line_word;
            case (alu_result[1:0])
                2'd0:    merged_word[31:24] = rt_data[7:0];
                2'd1:    merged_word[23:16] = rt_data[7:0];
                2'd2:    merged_word[15:8]  = rt_data[7:0];
                default: merged_word[7:0]   = rt_data[7:0];
            endcase
        end
        for (int i = 0; i < 4; i++) begin
            mem_data_in[i]    = merged_word[31-8*i -: 8];
            cache_data_out[i] = load_hit ? line_word[31-8*i -: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state      <= IDLE;
            count      <= '0;
            valid_bits <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cache_en) begin
                        if (mem_write && (match || !is_LB_SB)) begin
                            state <= WR_WAIT;
                            count <= CNT_BITS'(1);
                        end else if (!match) begin
                            // Byte-store misses allocate first, then return here to write.
                            state <= RD_WAIT;
                            count <= CNT_BITS'(1);
                        end
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (last) begin
                        valid_bits[index] <= 1'b1;
                        state             <= IDLE;
                        count             <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // Data and tag arrays carry no reset; only the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (!rst_b && line_wr) begin
            data_ram[index] <= line_wr_word;
            tag_ram[index]  <= tag;
        end
    end

endmodule

// File: tb/tb_mips_dcache.sv
// Self-checking bench for mips_dcache: directed scenarios plus random traffic,
// scored against a line-presence model and a word-addressed memory image.

module tb_mips_dcache;

    localparam int INDEX_BITS = 11;
    localparam int LAT        = 4;
    localparam int NUM_LINES  = 2 ** INDEX_BITS;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        cache_en;
    logic        mem_write;
    logic        is_LB_SB;
    logic [31:0] alu_result;
    logic [31:0] rt_data;
    logic        hit;
    logic [7:0]  cache_data_out [0:3];
    logic [1:0]  mem_block;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in [0:3];
    logic        mem_write_en;
    logic [7:0]  mem_data_out [0:3];

    logic [31:0] mem_arr [0:16383];
    logic [31:0] mem_rd_word;
    bit          ref_valid [0:NUM_LINES-1];
    int unsigned ref_tag   [0:NUM_LINES-1];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_dcache #(.INDEX_BITS(INDEX_BITS), .MEM_LATENCY(LAT)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .cache_en       (cache_en),
        .mem_write      (mem_write),
        .is_LB_SB       (is_LB_SB),
        .alu_result     (alu_result),
        .rt_data        (rt_data),
        .hit            (hit),
        .cache_data_out (cache_data_out),
        .mem_block      (mem_block),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_write_en   (mem_write_en),
        .mem_data_out   (mem_data_out)
    );

    assign mem_rd_word = mem_arr[mem_addr[15:2]];
    always_comb begin
        for (int i = 0; i < 4; i++) mem_data_out[i] = mem_rd_word[31-8*i -: 8];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_hit(input logic [31:0] a);
        int unsigned idx;
        idx = (a / 4) % NUM_LINES;
        return ref_valid[idx] && (ref_tag[idx] == a / (4 * NUM_LINES));
    endfunction

    task automatic ref_fill(input logic [31:0] a);
        int unsigned idx;
        idx = (a / 4) % NUM_LINES;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = a / (4 * NUM_LINES);
    endtask

    task automatic ref_clear();
        for (int i = 0; i < NUM_LINES; i++) ref_valid[i] = 1'b0;
    endtask

    // Memory commits writes mid-cycle while the strobe and data are stable.
    task automatic cycle();
        if (mem_write_en === 1'b1)
            mem_arr[mem_addr[15:2]] = {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input string tag, input bit we, input bit bt,
                          input logic [31:0] a, input logic [31:0] d);
        int          exp_lat;
        int          n;
        int          wr_n;
        int          off;
        logic [31:0] exp_word;
        bit          present;
        present  = ref_hit(a);
        exp_word = mem_arr[a[15:2]];
        off      = int'(a[1:0]);
        if (!we) exp_lat = present ? 0 : LAT + 1;
        else if (!bt) begin
            exp_lat  = LAT;
            exp_word = d;
        end else begin
            exp_lat = present ? LAT : 2 * LAT + 1;
            exp_word[31-8*off -: 8] = d[7:0];
        end
        mem_write  = we;
        is_LB_SB   = bt;
        alu_result = a;
        rt_data    = d;
        cache_en   = 1'b1;
        #1;
        check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        check({tag, "_block"}, {30'd0, mem_block}, {30'd0, a[1:0]});
        n    = 0;
        wr_n = 0;
        while (hit !== 1'b1 && n < 3 * LAT + 6) begin
            if (mem_write_en === 1'b1) wr_n++;
            cycle();
            n++;
        end
        if (mem_write_en === 1'b1) wr_n++;
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_wr_cycles"}, wr_n, we ? LAT : 0);
        if (!we) begin
            check({tag, "_load_data"},
                  {cache_data_out[0], cache_data_out[1], cache_data_out[2], cache_data_out[3]}, exp_word);
        end else begin
            check({tag, "_store_word"},
                  {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]}, exp_word);
            check({tag, "_store_dout"},
                  {cache_data_out[0], cache_data_out[1], cache_data_out[2], cache_data_out[3]}, 32'h0);
        end
        cache_en = 1'b0;
        cycle();
        ref_fill(a);
    endtask

    initial begin
        int          hits_seen;
        logic [31:0] a;
        logic [31:0] d;
        bit          we;
        bit          bt;

        for (int i = 0; i < 16384; i++) mem_arr[i] = $urandom;
        mem_arr[32'h100 >> 2] = 32'hDEADBEEF;
        ref_clear();

        rst_b      = 1'b1;
        cache_en   = 1'b0;
        mem_write  = 1'b0;
        is_LB_SB   = 1'b0;
        alu_result = 32'h0;
        rt_data    = 32'h0;
        repeat (3) cycle();
        rst_b = 1'b0;
        #1;
        check("reset_hit", {31'd0, hit}, 32'd0);
        check("reset_mem_we", {31'd0, mem_write_en}, 32'd0);
        check("reset_dout", {cache_data_out[0], cache_data_out[1], cache_data_out[2], cache_data_out[3]}, 32'h0);

        do_req("load_cold_100", 1'b0, 1'b0, 32'h100, 32'h0);
        do_req("load_warm_100", 1'b0, 1'b0, 32'h100, 32'h0);
        do_req("word_store_100", 1'b1, 1'b0, 32'h100, 32'h11223344);
        do_req("load_after_store", 1'b0, 1'b0, 32'h100, 32'h0);
        do_req("byte_store_203", 1'b1, 1'b1, 32'h203, 32'h000000AA);
        do_req("load_after_sb", 1'b0, 1'b1, 32'h200, 32'h0);
        do_req("byte_store_hit", 1'b1, 1'b1, 32'h201, 32'h0000005C);

        do_req("alias_0000", 1'b0, 1'b0, 32'h0000, 32'h0);
        do_req("alias_2000", 1'b0, 1'b0, 32'h2000, 32'h0);
        do_req("alias_reload", 1'b0, 1'b0, 32'h0000, 32'h0);

        // Reset lands in the second WR_WAIT cycle of a word store.
        mem_write  = 1'b1;
        is_LB_SB   = 1'b0;
        alu_result = 32'h300;
        rt_data    = 32'hCAFEF00D;
        cache_en   = 1'b1;
        cycle();
        cycle();
        rst_b = 1'b1;
        cycle();
        check("abort_mem_we", {31'd0, mem_write_en}, 32'd0);
        check("abort_hit", {31'd0, hit}, 32'd0);
        rst_b    = 1'b0;
        cache_en = 1'b0;
        cycle();
        ref_clear();
        do_req("load_after_abort", 1'b0, 1'b0, 32'h300, 32'h0);

        // Requester withdraws during the fill; the line must still be allocated.
        mem_write  = 1'b0;
        is_LB_SB   = 1'b0;
        alu_result = 32'h4A8;
        cache_en   = 1'b1;
        cycle();
        cache_en  = 1'b0;
        hits_seen = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            if (hit === 1'b1) hits_seen++;
            cycle();
        end
        check("drop_no_hit", hits_seen, 0);
        ref_fill(32'h4A8);
        do_req("load_after_drop", 1'b0, 1'b0, 32'h4A8, 32'h0);

        for (int k = 0; k < 40; k++) begin
            we = 1'($urandom_range(0, 1));
            bt = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 3)) * 32'h2000 + 32'($urandom_range(0, 7)) * 4;
            if (bt || !we) a = a + 32'($urandom_range(0, 3));
            d = $urandom;
            do_req($sformatf("rand%0d", k), we, bt, a, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
